// File: rtl/return_addr_stack_pkg.sv
// Shared sizing and operation decode for the return-address stack.
package return_addr_stack_pkg;

  localparam int unsigned PCSIZE    = 32;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned RAS_PTR_W = 3;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } ras_op_e;

  // Flush and stall suppress everything; push+pop on an empty stack acts as a push.
  function automatic ras_op_e decode_op(input logic push, input logic pop,
                                        input logic stall, input logic flush,
                                        input logic empty);
    if (stall || flush)   return OP_NONE;
    if (push && pop)      return empty ? OP_PUSH : OP_REPLACE;
    if (push)             return OP_PUSH;
    if (pop && !empty)    return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/return_addr_stack_ras_storage.sv
// Return-address register file: one synchronous write port, one asynchronous read port.
module ras_storage
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned PTR_W = RAS_PTR_W,
  parameter int unsigned WIDTH = PCSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: pushes link addresses from decode, predicts JR $31 targets for fetch.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned PTR_W = RAS_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              push_i,
  input  logic [PCSIZE-1:0] push_addr_i,
  input  logic              pop_i,
  output logic              pred_valid_o,
  output logic [PCSIZE-1:0] pred_addr_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [PTR_W:0] COUNT_MAX = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] top;
  logic [PTR_W:0]   count;
  ras_op_e          op;
  logic             we;
  logic [PTR_W-1:0] waddr;

  assign empty_o      = (count == '0);
  assign full_o       = (count == COUNT_MAX);
  assign pred_valid_o = ~empty_o;

  assign op = decode_op(push_i, pop_i, stallD, flushD, empty_o);

  always_comb begin
    we    = 1'b0;
    waddr = top;
    unique case (op)
      OP_PUSH: begin
        we    = 1'b1;
        waddr = top + 1'b1;
      end
      OP_REPLACE: we = 1'b1;
      default: ;
    endcase
  end

  // Full-stack pushes wrap the ring and silently overwrite the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
    end else if (flushD) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          top <= top + 1'b1;
          if (count != COUNT_MAX) count <= count + 1'b1;
        end
        OP_POP: begin
          top   <= top - 1'b1;
          count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  ras_storage #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .WIDTH(PCSIZE)
  ) u_storage (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .wdata(push_addr_i),
    .raddr(top),
    .rdata(pred_addr_o)
  );

endmodule

// File: tb/tb_return_addr_stack.sv
// Randomized and directed check of return_addr_stack against a ring-buffer reference model.
module tb_return_addr_stack;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, stallD, flushD, push_i, pop_i;
  logic [31:0] push_addr_i;
  logic        pred_valid_o, empty_o, full_o;
  logic [31:0] pred_addr_o;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // Reference model: ring of DEPTH slots, a top index and a saturating occupancy.
  logic [31:0] m_mem [DEPTH];
  int          m_top = 0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
    .push_i(push_i), .push_addr_i(push_addr_i), .pop_i(pop_i),
    .pred_valid_o(pred_valid_o), .pred_addr_o(pred_addr_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_top = 0;
      m_cnt = 0;
    end else if (flushD) begin
      m_cnt = 0;
    end else if (!stallD) begin
      if (push_i && pop_i && m_cnt > 0) begin
        m_mem[m_top] = push_addr_i;
      end else if (push_i) begin
        m_top = (m_top + 1) % DEPTH;
        m_mem[m_top] = push_addr_i;
        if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
      end else if (pop_i && m_cnt > 0) begin
        m_top = (m_top + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors += 4;
      if (pred_valid_o !== (m_cnt > 0)) begin
        errors++;
        $display("FAIL model_valid t=%0t got=%b exp=%b", $time, pred_valid_o, m_cnt > 0);
      end
      if (pred_addr_o !== m_mem[m_top]) begin
        errors++;
        $display("FAIL model_addr t=%0t got=%h exp=%h", $time, pred_addr_o, m_mem[m_top]);
      end
      if (empty_o !== (m_cnt == 0)) begin
        errors++;
        $display("FAIL model_empty t=%0t got=%b exp=%b", $time, empty_o, m_cnt == 0);
      end
      if (full_o !== (m_cnt == DEPTH)) begin
        errors++;
        $display("FAIL model_full t=%0t got=%b exp=%b", $time, full_o, m_cnt == DEPTH);
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic pu, input logic [31:0] a, input logic po);
    rst = r; stallD = st; flushD = fl; push_i = pu; push_addr_i = a; pop_i = po;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // 1: reset then idle
    step(0, 0, 0, 0, 0, 0);
    lit("rst_valid", {31'b0, pred_valid_o}, 32'd0);
    lit("rst_addr", pred_addr_o, 32'h0);
    lit("rst_empty", {31'b0, empty_o}, 32'd1);
    lit("rst_full", {31'b0, full_o}, 32'd0);

    // 2: two pushes, two pops
    step(0, 0, 0, 1, 32'hBFC00010, 0);
    step(0, 0, 0, 1, 32'hBFC00020, 0);
    lit("push2_top", pred_addr_o, 32'hBFC00020);
    step(0, 0, 0, 0, 0, 1);
    lit("pop1_addr", pred_addr_o, 32'hBFC00010);
    lit("pop1_valid", {31'b0, pred_valid_o}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    lit("pop2_empty", {31'b0, empty_o}, 32'd1);

    // 3: overfill by one, then drain
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) step(0, 0, 0, 1, 32'h100 * k, 0);
    lit("ovf_full", {31'b0, full_o}, 32'd1);
    lit("ovf_top", pred_addr_o, 32'h900);
    for (int k = 0; k < 8; k++) begin
      lit("drain_addr", pred_addr_o, 32'h900 - 32'h100 * k);
      step(0, 0, 0, 0, 0, 1);
    end
    lit("drain_empty", {31'b0, empty_o}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    lit("pop_on_empty", {31'b0, empty_o}, 32'd1);

    // 4: push+pop replaces top
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h300, 0);
    step(0, 0, 0, 1, 32'h400, 0);
    step(0, 0, 0, 1, 32'h500, 1);
    lit("replace_top", pred_addr_o, 32'h500);
    step(0, 0, 0, 0, 0, 1);
    lit("replace_below", pred_addr_o, 32'h300);
    lit("replace_valid", {31'b0, pred_valid_o}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    lit("replace_empty", {31'b0, empty_o}, 32'd1);
    step(0, 0, 0, 1, 32'h600, 1);
    lit("pushpop_on_empty", pred_addr_o, 32'h600);

    // 5: stall holds, flush empties
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 32'hDEAD0000 + k, 0);
    lit("stall_hold", pred_addr_o, 32'h600);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 32'hA00 + k, 0);
    lit("pre_flush_top", pred_addr_o, 32'hA03);
    step(0, 1, 1, 1, 32'hBEEF, 1);
    lit("flush_empty", {31'b0, empty_o}, 32'd1);
    lit("flush_valid", {31'b0, pred_valid_o}, 32'd0);

    // 6: reset beats a concurrent push
    step(1, 0, 0, 1, 32'h700, 0);
    lit("rst_push_addr", pred_addr_o, 32'h0);
    lit("rst_push_empty", {31'b0, empty_o}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 97) == 0, ($urandom % 8) == 0, ($urandom % 20) == 0,
           ($urandom % 2) == 1, $urandom, ($urandom % 5) < 2);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
